calc_seq: RTL and testbench

Parametrised successor of the board-level four-button calculator. Operands A and B are read from the DIP switches. Four buttons launch add, subtract, multiply and multiply-accumulate. The 2W-bit result register drives the LEDs. Buttons are synchronised and edge-detected inside the block, and multiply/MAC run as a W-cycle shift-add sequence with a busy flag and a sticky overflow flag.

---
 rtl/calc_pkg.sv | 8 +
 rtl/btn_edge.sv | 24 ++
 rtl/calc_seq.sv | 106 ++++++++++
 tb/tb_calc_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared op/state encodings and sizing helper for the calculator
package calc_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_MAC} op_e;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: per-button 2-flop synchroniser with rising-edge pulse output
module btn_edge #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] press_o
);
  logic [N-1:0] s1_q, s2_q, prev_q;
  // synchronise the raw buttons and remember the last synchronised value
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign press_o = s2_q & ~prev_q;
endmodule

// File: rtl/calc_seq.sv
// calc_seq: button-driven add/sub/shift-add multiply/MAC calculator
module calc_seq
  import calc_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*W-1:0] dip_sw,
  input  logic [3:0]     btn,
  output logic [2*W-1:0] leds,
  output logic           busy,
  output logic           ovf
);
  localparam int CW = cnt_width(W);
  logic [3:0]     press;
  op_e            op;
  state_e         state_q, state_d;
  logic [2*W-1:0] mcand_q, mcand_d, leds_q, leds_d;
  logic [W-1:0]   mplr_q, mplr_d, a_in, b_in;
  logic [2*W:0]   acc_q, acc_d, sum;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;

  btn_edge #(.N(4)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn),
    .press_o (press)
  );

  assign a_in = dip_sw[2*W-1:W];
  assign b_in = dip_sw[W-1:0];
  assign op   = press[0] ? OP_ADD : press[1] ? OP_SUB : press[2] ? OP_MUL : OP_MAC;
  assign sum  = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : '0);

  // register file for FSM, operands, accumulator and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      leds_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
      ovf_q   <= ovf_d;
    end
  end

  // accept one prioritised press in IDLE; step the shift-add multiplier in RUN
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    leds_d  = leds_q;
    ovf_d   = ovf_q;
    if (state_q == ST_IDLE && |press) begin
      mcand_d = {{W{1'b0}}, a_in};
      mplr_d  = b_in;
      cnt_d   = '0;
      case (op)
        OP_ADD: begin
          leds_d = {{W{1'b0}}, a_in} + {{W{1'b0}}, b_in};
          ovf_d  = 1'b0;
        end
        OP_SUB: begin
          leds_d = {{W{1'b0}}, a_in} - {{W{1'b0}}, b_in};
          ovf_d  = 1'b0;
        end
        OP_MUL: begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end
        OP_MAC: begin
          acc_d   = {1'b0, leds_q};
          state_d = ST_RUN;
        end
      endcase
    end else if (state_q == ST_RUN) begin
      acc_d   = sum;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        leds_d  = sum[2*W-1:0];
        ovf_d   = ovf_q | sum[2*W];
        state_d = ST_IDLE;
      end
    end
  end

  assign leds = leds_q;
  assign busy = (state_q == ST_RUN);
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: directed self-checking bench for calc_seq with W=4
module tb_calc_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dip_sw;
  logic [3:0] btn;
  logic [7:0] leds;
  logic       busy, ovf;
  int vectors = 0;
  int miscompares = 0;

  calc_seq #(.W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .dip_sw (dip_sw),
    .btn    (btn),
    .leds   (leds),
    .busy   (busy),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; dip_sw = 8'h00; btn = 4'h0;
    tick(3);
    rst = 1'b0;
    chk("rst_leds", leds, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    tick(1);
    // ADD 2+1, exact latency
    dip_sw = 8'h21; btn = 4'b0001;
    tick(2);
    chk("add_early", leds, 8'h00);
    tick(1);
    chk("add_leds", leds, 8'h03);
    chk("add_busy", busy, 1'b0);
    btn = 4'h0;
    tick(2);
    chk("add_busy2", busy, 1'b0);
    // SUB 1-2 wraps
    dip_sw = 8'h12; btn = 4'b0010;
    tick(3);
    chk("sub_leds", leds, 8'hFF);
    chk("sub_ovf", ovf, 1'b0);
    btn = 4'h0;
    tick(2);
    // MUL 15*15, busy exactly 4 cycles
    dip_sw = 8'hFF; btn = 4'b0100;
    tick(2);
    chk("mul_busy_pre", busy, 1'b0);
    tick(1);
    chk("mul_busy_e2", busy, 1'b1);
    btn = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("mul_busy_run", busy, 1'b1);
    end
    chk("mul_leds_hold", leds, 8'hFF);
    tick(1);
    chk("mul_busy_end", busy, 1'b0);
    chk("mul_leds", leds, 8'hE1);
    chk("mul_ovf", ovf, 1'b0);
    tick(1);
    // MAC 225 + 225 = 0x1C2 overflows
    btn = 4'b1000;
    tick(3);
    chk("mac_busy", busy, 1'b1);
    btn = 4'h0;
    tick(4);
    chk("mac_busy_end", busy, 1'b0);
    chk("mac_leds", leds, 8'hC2);
    chk("mac_ovf", ovf, 1'b1);
    tick(1);
    // ADD clears ovf
    dip_sw = 8'h11; btn = 4'b0001;
    tick(3);
    chk("add2_leds", leds, 8'h02);
    chk("add2_ovf", ovf, 1'b0);
    btn = 4'h0;
    tick(2);
    // ADD+MUL held: ADD wins once, no retrigger
    dip_sw = 8'h21; btn = 4'b0101;
    tick(3);
    chk("prio_leds", leds, 8'h03);
    chk("prio_busy", busy, 1'b0);
    dip_sw = 8'h33;
    for (int i = 0; i < 17; i++) begin
      tick(1);
      chk("hold_busy", busy, 1'b0);
    end
    chk("hold_leds", leds, 8'h03);
    btn = 4'h0;
    tick(2);
    // reset during second RUN cycle
    dip_sw = 8'hFF; btn = 4'b0100;
    tick(3);
    chk("rmul_busy", busy, 1'b1);
    btn = 4'h0;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("rmul_leds", leds, 8'h00);
    chk("rmul_busy0", busy, 1'b0);
    rst = 1'b0;
    tick(2);
    chk("rmul_idle", busy, 1'b0);
    // press and DIP change during RUN ignored
    dip_sw = 8'h23; btn = 4'b0100;
    tick(3);
    chk("ign_busy", busy, 1'b1);
    btn = 4'h0;
    tick(1);
    btn = 4'b0001; dip_sw = 8'h11;
    tick(3);
    chk("ign_busy_end", busy, 1'b0);
    chk("ign_leds", leds, 8'h06);
    tick(3);
    chk("ign_leds_hold", leds, 8'h06);
    btn = 4'h0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
